// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
//   Turns single-beat commands into AHB-Lite transfers, one at a time.
//   Each accepted command produces exactly one RSP_VALID pulse, unless it is
//   aborted by HRESET.
//
// Ports
//   HCLK, HRESET                  clock, async active-high reset
//   CMD_VALID/CMD_READY           command handshake (ready only in IDLE)
//   CMD_WRITE/ADDR/WDATA/SIZE     command fields
//   RSP_VALID/RSP_RDATA/RSP_ERROR completion pulse and result
//   H* outputs                    registered AHB-Lite master signals
//   HRDATA/HREADY/HRESP           AHB-Lite slave returns
`timescale 1ns/1ps
module ahb_cmd_master #(
   parameter int          AWIDTH  = 32,
   parameter int          TIMEOUT = 256,
   parameter logic [3:0]  PROT    = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [AWIDTH-1:0] CMD_ADDR,
   input  logic [31:0]       CMD_WDATA,
   input  logic [2:0]        CMD_SIZE,
   output logic              RSP_VALID,
   output logic [31:0]       RSP_RDATA,
   output logic              RSP_ERROR,
   output logic [AWIDTH-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic              HMASTLOCK,
   output logic [3:0]        HPROT,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, REJ} state_t;

   localparam logic [1:0]  TR_IDLE   = 2'b00;
   localparam logic [1:0]  TR_NONSEQ = 2'b10;
   // Wait-count value at which the next HREADY-low cycle is the TIMEOUT-th.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic        write_q;
   logic [31:0] wdata_q;
   logic [15:0] wait_cnt;
   logic        illegal;

   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = PROT;

   // Sizes above word, or addresses not aligned to the transfer size.
   assign illegal = (CMD_SIZE > 3'd2) ||
                    ((CMD_SIZE == 3'd1) && CMD_ADDR[0]) ||
                    ((CMD_SIZE == 3'd2) && (CMD_ADDR[1:0] != 2'b00));

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= IDLE;
         CMD_READY <= 1'b0;
         RSP_VALID <= 1'b0;
         RSP_RDATA <= '0;
         RSP_ERROR <= 1'b0;
         HTRANS    <= TR_IDLE;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HSIZE     <= 3'b000;
         HWDATA    <= '0;
         wait_cnt  <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
      end else begin
         RSP_VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (CMD_VALID && CMD_READY) begin
                  CMD_READY <= 1'b0;
                  write_q   <= CMD_WRITE;
                  wdata_q   <= CMD_WDATA;
                  if (illegal) begin
                     // No bus activity; the error is reported next cycle.
                     state <= REJ;
                  end else begin
                     state  <= ADDR;
                     HTRANS <= TR_NONSEQ;
                     HADDR  <= CMD_ADDR;
                     HWRITE <= CMD_WRITE;
                     HSIZE  <= CMD_SIZE;
                  end
               end else begin
                  // Also raises READY on the first edge out of reset.
                  CMD_READY <= 1'b1;
               end
            end
            ADDR: begin
               if (HREADY) begin
                  state    <= DATA;
                  HTRANS   <= TR_IDLE;
                  wait_cnt <= '0;
                  if (write_q) HWDATA <= wdata_q;
               end
            end
            DATA: begin
               if (HREADY) begin
                  // HRESP on the HREADY-high cycle is the second ERROR cycle.
                  RSP_VALID <= 1'b1;
                  RSP_ERROR <= HRESP;
                  RSP_RDATA <= (!write_q && !HRESP) ? HRDATA : 32'h0;
                  CMD_READY <= 1'b1;
                  state     <= IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  RSP_VALID <= 1'b1;
                  RSP_ERROR <= 1'b1;
                  RSP_RDATA <= 32'h0;
                  CMD_READY <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            REJ: begin
               RSP_VALID <= 1'b1;
               RSP_ERROR <= 1'b1;
               RSP_RDATA <= 32'h0;
               CMD_READY <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, the width of the command and AHB address.
REQ-002 SHALL have parameter TIMEOUT, default 256, the maximum HREADY-low cycles allowed in one data phase (range 1..65535).
REQ-003 SHALL have parameter PROT, default 4'b0011, the constant HPROT value.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: HCLK and HRESET.
REQ-005 HCLK  in  1  rising-edge clock for all logic.
REQ-006 HRESET  in  1  asynchronous, active-high reset.
REQ-007 CMD_VALID  in  1  command request.
REQ-008 CMD_READY  out  1  block can accept a command.
REQ-009 CMD_WRITE  in  1  1 = write, 0 = read.
REQ-010 CMD_ADDR  in  AWIDTH  byte address.
REQ-011 CMD_WDATA  in  32  write data, on AHB byte lanes.
REQ-012 CMD_SIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
REQ-013 RSP_VALID  out  1  one-cycle completion pulse.
REQ-014 RSP_RDATA  out  32  read data; 0 for writes and errors.
REQ-015 RSP_ERROR  out  1  transfer failed (slave ERROR, misaligned or illegal size, timeout).
REQ-016 HADDR/HTRANS/HWRITE/HSIZE/HBURST/HMASTLOCK/HPROT/HWDATA  out  AWIDTH/2/1/3/3/1/4/32  AHB-Lite master outputs.
REQ-017 HRDATA/HREADY/HRESP  in  32/1/1  AHB-Lite slave returns.

Function
REQ-018 SHALL implement an FSM with states IDLE, ADDR, DATA and REJ, with all AHB outputs registered.
REQ-019 SHALL assert CMD_READY only in IDLE; a command is accepted on an edge where CMD_VALID and CMD_READY are both 1.
REQ-020 SHALL, on accepting a legal command, capture all CMD_* fields, go to ADDR and drive HTRANS=2'b10 (NONSEQ) with HADDR, HWRITE and HSIZE from the captured fields.
REQ-021 SHALL stay in ADDR while HREADY=0; on the first edge with HREADY=1 it goes to DATA, drives HTRANS=2'b00 and drives HWDATA = captured data (writes) or holds the previous value (reads).
REQ-022 SHALL, in DATA, on an edge with HREADY=1: capture HRDATA (reads only), pulse RSP_VALID for one cycle with RSP_ERROR=HRESP, and return to IDLE.
REQ-023 SHALL, when HRESP=1 with HREADY=0 (first ERROR cycle), keep waiting and report the error on the HREADY=1 cycle; it issues no new transfer in between.
REQ-024 SHALL treat a command as illegal when CMD_SIZE>2, or CMD_SIZE=1 with ADDR[0]≠0, or CMD_SIZE=2 with ADDR[1:0]≠0.
REQ-025 SHALL handle an illegal command as follows: accept it, enter REJ, generate no AHB activity (HTRANS stays 00), pulse RSP_VALID with RSP_ERROR=1 in the following cycle, then return to IDLE.
REQ-026 SHALL count consecutive HREADY=0 cycles in DATA with a 16-bit counter, cleared on entering DATA.
REQ-027 SHALL, when the count reaches TIMEOUT, pulse RSP_VALID with RSP_ERROR=1 and RSP_RDATA=0, and return to IDLE.
REQ-028 SHALL give latency with zero wait states of exactly 2 edges from accept: RSP_VALID is high in the cycle after the second edge.
REQ-029 SHALL give RSP_VALID no backpressure, and SHALL allow CMD_READY=1 in the same cycle as RSP_VALID, so back-to-back commands are possible.
REQ-030 SHALL hold HBURST=3'b000, HMASTLOCK=0 and HPROT=PROT constant.
REQ-031 SHALL leave RSP_RDATA and RSP_ERROR stable until the next RSP_VALID.

Reset
REQ-032 SHALL, while HRESET=1, force state=IDLE and set to 0 immediately (asynchronously): CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERROR, HTRANS, HADDR, HWRITE, HSIZE, HWDATA and the timeout counter.
REQ-033 SHALL raise CMD_READY from the first HCLK edge after HRESET deasserts.
REQ-034 SHALL, on reset asserted mid-transfer, drop HTRANS to 00 at once and produce no RSP_VALID for the aborted command.

Verification
REQ-035 Write: ADDR 0x100, WDATA 0xDEADBEEF, SIZE 2, HREADY=1 -> HTRANS=10 for 1 cycle, HWDATA=0xDEADBEEF next cycle, RSP_VALID=1 with RSP_ERROR=0 in the cycle after edge 2.
REQ-036 Read: ADDR 0x204, SIZE 2, 3 wait states, HRDATA=0x12345678 -> RSP_RDATA=0x12345678, RSP_VALID at edge 5.
REQ-037 Error: two-cycle ERROR (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> RSP_ERROR=1, no second NONSEQ.
REQ-038 Misaligned: ADDR 0x102, SIZE 2 -> HTRANS stays 00, RSP_VALID with RSP_ERROR=1 one cycle after accept; repeat with SIZE=3.
REQ-039 Timeout: TIMEOUT=4, HREADY held 0 in data phase -> RSP_ERROR=1 after 4 wait cycles, FSM returns to IDLE.
REQ-040 Reset mid-transfer: HRESET=1 during DATA -> all outputs 0 asynchronously, no RSP_VALID, CMD_READY=1 one edge after release.
